// File: rtl/axil_master_arbiter_pkg.sv
// Shared types and AXI4-Lite constants for the command/response arbiter
// and anything else that reuses its round-robin sub-block.
package axil_arb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR,
      WR_RESP,
      RD,
      RD_DATA,
      RESP
   } state_t;

   localparam logic [1:0] RESP_OKAY    = 2'b00;
   localparam logic [1:0] RESP_SLVERR  = 2'b10;
   localparam logic [1:0] RESP_DECERR  = 2'b11;

   localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axil_master_arbiter_if.sv
// AXI4-Lite bus bundle; the arbiter takes the master modport, the
// responding register file or VIP takes the slave modport.
interface axil_master_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);

   logic                  awvalid;
   logic                  awready;
   logic [ADDR_W-1:0]     awaddr;
   logic [2:0]            awprot;
   logic                  wvalid;
   logic                  wready;
   logic [DATA_W-1:0]     wdata;
   logic [DATA_W/8-1:0]   wstrb;
   logic                  bvalid;
   logic                  bready;
   logic [1:0]            bresp;
   logic                  arvalid;
   logic                  arready;
   logic [ADDR_W-1:0]     araddr;
   logic [2:0]            arprot;
   logic                  rvalid;
   logic                  rready;
   logic [DATA_W-1:0]     rdata;
   logic [1:0]            rresp;

   modport master (
      output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
             arvalid, araddr, arprot, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

   modport slave (
      input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
             arvalid, araddr, arprot, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

endinterface

// File: rtl/axil_master_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or above the pointer
// (with wrap) and moves the pointer just past the winner on each grant.
module rr_arbiter #(
   parameter int N = 4,
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [N-1:0]     req,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grantIdx,
   output logic             grantValid
);

   logic [IDX_W-1:0] pointer_q, pointer_d;

   always_comb begin
      int idx;
      idx        = 0;
      grant      = '0;
      grantIdx   = '0;
      grantValid = 1'b0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(pointer_q) + k) % N;
         if (enable && !grantValid && req[idx]) begin
            grant[idx] = 1'b1;
            grantIdx   = IDX_W'(idx);
            grantValid = 1'b1;
         end
      end
   end

   // Wrap explicitly so non-power-of-two N never lands on an unused index.
   always_comb begin
      pointer_d = pointer_q;
      if (grantValid) begin
         pointer_d = (grantIdx == IDX_W'(N - 1)) ? '0 : grantIdx + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pointer_q <= '0;
      end else begin
         pointer_q <= pointer_d;
      end
   end

endmodule

// File: rtl/axil_master_arbiter.sv
// AXI4-Lite master shared by NUM_REQ requesters over a command/response
// port: round-robin grants, one transaction in flight at a time.
module axil_master_arbiter
   import axil_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32
) (
   input  logic                      aclk,
   input  logic                      areset,
   input  logic [NUM_REQ-1:0]        cmd_valid,
   output logic [NUM_REQ-1:0]        cmd_ready,
   input  logic [NUM_REQ-1:0]        cmd_we,
   input  logic [NUM_REQ*ADDR_W-1:0] cmd_addr,
   input  logic [NUM_REQ*DATA_W-1:0] cmd_wdata,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic [1:0]                rsp_resp,
   output logic                      busy,
   axil_master_arbiter_if.master     m_axi
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    grantIdx_q, grantIdx_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                awDone_q, awDone_d;
   logic                wDone_q, wDone_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [1:0]          resp_q, resp_d;

   logic [NUM_REQ-1:0]  arbGrant;
   logic [IDX_W-1:0]    arbIdx;
   logic                arbValid;
   logic                arbEnable;
   logic                awHs;
   logic                wHs;

   // Grants are only taken in IDLE and never in a reset cycle, so a
   // captured command always maps to a transaction that will be issued.
   assign arbEnable = (state_q == IDLE) && !areset;

   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .clk        (aclk),
      .rst        (areset),
      .enable     (arbEnable),
      .req        (cmd_valid),
      .grant      (arbGrant),
      .grantIdx   (arbIdx),
      .grantValid (arbValid)
   );

   assign awHs = m_axi.awvalid && m_axi.awready;
   assign wHs  = m_axi.wvalid && m_axi.wready;

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (arbValid) state_d = cmd_we[arbIdx] ? WR : RD;
         WR:      if ((awDone_q || awHs) && (wDone_q || wHs)) state_d = WR_RESP;
         WR_RESP: if (m_axi.bvalid) state_d = RESP;
         RD:      if (m_axi.arready) state_d = RD_DATA;
         RD_DATA: if (m_axi.rvalid) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // AW and W complete independently; the done flags remember which one
   // already handshook so its valid drops while the other keeps waiting.
   always_comb begin
      grantIdx_d = grantIdx_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      awDone_d   = awDone_q;
      wDone_d    = wDone_q;
      rdata_d    = rdata_q;
      resp_d     = resp_q;
      if (arbValid) begin
         grantIdx_d = arbIdx;
         addr_d     = cmd_addr[int'(arbIdx)*ADDR_W +: ADDR_W];
         wdata_d    = cmd_wdata[int'(arbIdx)*DATA_W +: DATA_W];
         awDone_d   = 1'b0;
         wDone_d    = 1'b0;
      end
      if (awHs) awDone_d = 1'b1;
      if (wHs)  wDone_d  = 1'b1;
      if ((state_q == WR_RESP) && m_axi.bvalid) begin
         resp_d  = m_axi.bresp;
         rdata_d = '0;
      end
      if ((state_q == RD_DATA) && m_axi.rvalid) begin
         resp_d  = m_axi.rresp;
         rdata_d = m_axi.rdata;
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         grantIdx_q <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         awDone_q   <= 1'b0;
         wDone_q    <= 1'b0;
         rdata_q    <= '0;
         resp_q     <= '0;
      end else begin
         grantIdx_q <= grantIdx_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         awDone_q   <= awDone_d;
         wDone_q    <= wDone_d;
         rdata_q    <= rdata_d;
         resp_q     <= resp_d;
      end
   end

   always_comb begin
      m_axi.awvalid = (state_q == WR) && !awDone_q;
      m_axi.awaddr  = addr_q;
      m_axi.awprot  = PROT_DEFAULT;
      m_axi.wvalid  = (state_q == WR) && !wDone_q;
      m_axi.wdata   = wdata_q;
      m_axi.wstrb   = '1;
      m_axi.bready  = (state_q == WR_RESP);
      m_axi.arvalid = (state_q == RD);
      m_axi.araddr  = addr_q;
      m_axi.arprot  = PROT_DEFAULT;
      m_axi.rready  = (state_q == RD_DATA);
      cmd_ready     = arbGrant;
      rsp_valid     = '0;
      if (state_q == RESP) rsp_valid[grantIdx_q] = 1'b1;
      rsp_rdata     = (state_q == RESP) ? rdata_q : '0;
      rsp_resp      = (state_q == RESP) ? resp_q : RESP_OKAY;
      busy          = (state_q != IDLE) || arbValid;
   end

endmodule

// File: doc/axil_master_arbiter.md
Name: axil_master_arbiter

Overview:
- Shares one AXI4-Lite master port between NUM_REQ local requesters using a simple command/response interface.
- Round-robin arbitration; exactly one transaction outstanding at a time.
- Sits between control engines (DMA setup, config sequencers) and the AXI VIP / register-file slave in design_1.
- The bench drives requesters directly; an AXI VIP slave (or the existing register slave) answers on the master side.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 32, AXI address width
- DATA_W, 32, AXI data width (fixed 32; wstrb all ones)

Ports:
- aclk  in  1  clock, single domain
- areset  in  1  synchronous, active-high reset
- cmd_valid  in  NUM_REQ  per-requester command present
- cmd_ready  out  NUM_REQ  one-hot, one-cycle pulse: command captured
- cmd_we  in  NUM_REQ  1 = write, 0 = read
- cmd_addr  in  NUM_REQ*ADDR_W  flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
- cmd_wdata  in  NUM_REQ*DATA_W  flattened write data
- rsp_valid  out  NUM_REQ  one-hot, one-cycle pulse: transaction complete
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid (0 for writes)
- rsp_resp  out  2  BRESP/RRESP, valid with rsp_valid
- busy  out  1  high from grant through the rsp_valid cycle
- m_axi_aw{valid,ready,addr,prot}, m_axi_w{valid,ready,data,strb}, m_axi_b{valid,ready,resp}, m_axi_ar{valid,ready,addr,prot}, m_axi_r{valid,ready,data,resp}  standard AXI4-Lite master directions and widths

Behaviour:
- Reset (areset=1 at a posedge):
  - All outputs 0: cmd_ready, rsp_valid, rsp_rdata, rsp_resp, busy, every m_axi_*valid and *ready.
  - State IDLE; round-robin pointer = 0.
  - Reset mid-transaction drops valids at that edge. No response is issued for the aborted command.
- States: IDLE, WR, WR_RESP, RD, RD_DATA, RESP.
- IDLE:
  - If any cmd_valid is set, grant the first set bit scanning from the pointer upward with wrap.
  - cmd_ready[g] is combinational and asserted in that same cycle.
  - Register addr, wdata, we and grant index. Pointer becomes (g+1) mod NUM_REQ.
  - Go to WR if we=1, else RD.
  - No cmd_valid: stay in IDLE, pointer unchanged.
- WR:
  - awvalid and wvalid are asserted from the first WR cycle.
  - Each channel drops independently after its own handshake (aw_done / w_done flags). Both handshakes may occur in the same cycle or in either order.
  - When both are done, go to WR_RESP.
  - awprot = 3'b000; wstrb = 4'hF. Address is passed through unaltered (no alignment).
- WR_RESP: bready=1. On bvalid, capture bresp, set rdata=0, go to RESP.
- RD: arvalid=1 until arready, then go to RD_DATA; arprot = 3'b000.
- RD_DATA: rready=1. On rvalid, capture rdata and rresp, go to RESP.
- RESP: rsp_valid[g]=1 for exactly one cycle, then IDLE.
  - A new grant is possible on the cycle after RESP.
  - Minimum issue-to-issue spacing is 4 cycles with zero-wait-state slaves.
- Latency (zero-wait slave):
  - cmd_ready at T, AW/W valid at T+1, bvalid earliest T+2, rsp_valid T+3.
  - Reads follow the same timing.
- cmd_valid deasserted before cmd_ready: treated as never requested. No AXI protocol obligation on requesters beyond holding fields while cmd_valid is high.
- No starvation: a continuously requesting requester waits at most NUM_REQ-1 grants.
- SLVERR/DECERR are forwarded in rsp_resp without retry.
- No timeout: a hung slave holds busy indefinitely.

Decomposition:
- Package axil_arb_pkg holds:
  - state_t enum
  - AXI response constants (RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11)
  - PROT_DEFAULT = 3'b000
- Sub-module rr_arbiter (parameter N): inputs req, pointer, enable; outputs one-hot grant and grant index.
  - Purely combinational plus pointer register.
  - Reused by other shared-resource blocks.

Test Plan:
- Single write: req0 writes 0xDEADBEEF to 0x0 -> one AW/W beat with awaddr=0, wdata=DEADBEEF, wstrb=F; rsp_valid[0] pulse with rsp_resp=00.
- Read-back: req1 reads 0x0 after the write -> rsp_valid[1] with rsp_rdata=DEADBEEF, rsp_resp=00.
- Contention: all four requesters assert together, pointer=0 -> grant order 0,1,2,3. With req0 reasserted immediately, next order is 0 after 3; no requester is granted twice before the others.
- Channel skew: slave delays wready 5 cycles after awready, then reverse order -> exactly one AW and one W handshake each, single rsp_valid, awvalid low after its handshake.
- Error: slave returns bresp=10 for write to 0x3 -> rsp_resp=10 on rsp_valid, arbiter returns to IDLE, next command serviced normally.
- Reset mid-op: assert areset while in WR_RESP -> all valids/readies and busy are 0 the next cycle, no rsp_valid pulse, pointer=0; the following command completes correctly.
